// File: rtl/usb_conn_mgr_pkg.sv
// Shared state encodings and next-state logic for the USB connection manager.
package usb_conn_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CONN = 2'd1,
        ST_SUSP = 2'd2,
        ST_DET  = 2'd3
    } conn_state_t;

    // Transition rules. t_exp is the timer expiry of whichever state is current.
    // Detach wins over everything; in SUSP the drop timer wins over sleep falling.
    function automatic conn_state_t next_state(conn_state_t st, logic detach, logic sleep, logic t_exp);
        conn_state_t nxt;
        nxt = st;
        case (st)
            ST_WAIT: if (t_exp) nxt = ST_CONN;
            ST_CONN: begin
                if (detach)      nxt = ST_DET;
                else if (sleep)  nxt = ST_SUSP;
            end
            ST_SUSP: begin
                if (detach)      nxt = ST_DET;
                else if (t_exp)  nxt = ST_DET;
                else if (!sleep) nxt = ST_CONN;
            end
            ST_DET:  if (t_exp && !detach) nxt = ST_WAIT;
            default: nxt = ST_WAIT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/usb_conn_mgr_if.sv
// Bus-side signals of the connection manager: suspend/detach inputs, pull-up/LED/status outputs.
interface usb_conn_mgr_if;
    logic       sleep_i;
    logic       detach_i;
    logic       usb_pu_o;
    logic       led_o;
    logic [1:0] state_o;
    logic       connected_o;

    modport master (
        output sleep_i, detach_i,
        input  usb_pu_o, led_o, state_o, connected_o
    );

    modport slave (
        input  sleep_i, detach_i,
        output usb_pu_o, led_o, state_o, connected_o
    );
endinterface

// File: rtl/usb_conn_mgr_ms_timer.sv
// Millisecond timebase: clock prescaler plus a saturating millisecond counter.
module ms_timer #(
    parameter int CLKS_PER_MS = 1000,
    parameter int MS_W        = 8
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            clr_i,
    input  logic            hold_i,
    output logic            ms_tick_o,
    output logic [MS_W-1:0] ms_cnt_o
);
    localparam int PW = $clog2(CLKS_PER_MS);
    localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0]   presc_q;
    logic [MS_W-1:0] cnt_q;

    assign ms_tick_o = !hold_i && (presc_q == PRESC_TC);
    assign ms_cnt_o  = cnt_q;

    // Prescaler wraps on terminal count; ms counter advances on each tick and sticks at all-ones.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i || hold_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= ms_tick_o ? '0 : presc_q + 1'b1;
            if (ms_tick_o && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/usb_conn_mgr.sv
// USB connection manager: pull-up sequencing, suspend tracking, soft detach and status LED.
module usb_conn_mgr
    import usb_conn_pkg::*;
#(
    parameter int CLK_HZ          = 1_000_000,
    parameter int CONNECT_MS      = 1000,
    parameter int DETACH_MS       = 10,
    parameter int SUSPEND_DROP_MS = 0,
    parameter int LED_BLINK_LOG2  = 7,
    parameter int SYNC_STAGES     = 2
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    usb_conn_mgr_if.slave  bus
);
    localparam int CLKS_PER_MS = CLK_HZ / 1000;
    localparam int MAX_A  = (CONNECT_MS > DETACH_MS) ? CONNECT_MS : DETACH_MS;
    localparam int MAX_MS = (MAX_A > SUSPEND_DROP_MS) ? MAX_A : SUSPEND_DROP_MS;
    localparam int CW     = $clog2(MAX_MS + 1);
    localparam int MS_W   = (CW > LED_BLINK_LOG2 + 1) ? CW : LED_BLINK_LOG2 + 1;

    localparam logic [MS_W-1:0] CONN_M1 = MS_W'(CONNECT_MS - 1);
    localparam logic [MS_W-1:0] DET_M1  = MS_W'(DETACH_MS - 1);
    localparam logic [MS_W-1:0] DET_N   = MS_W'(DETACH_MS);
    localparam logic [MS_W-1:0] DROP_M1 = MS_W'(SUSPEND_DROP_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sleep_s;
    logic                   ms_tick;
    logic [MS_W-1:0]        ms_cnt;
    logic [MS_W-1:0]        cnt_nxt;
    logic                   tmr_clr;
    logic                   tmr_hold;
    logic                   t_exp;
    conn_state_t            state_q;
    conn_state_t            state_nxt;
    logic                   pu_q;
    logic                   led_q;
    logic                   conn_q;

    // Bring the asynchronous suspend flag into the clk_i domain.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sleep_i};
    end
    assign sleep_s = sync_q[SYNC_STAGES-1];

    ms_timer #(.CLKS_PER_MS(CLKS_PER_MS), .MS_W(MS_W)) u_ms_timer (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (tmr_clr),
        .hold_i   (tmr_hold),
        .ms_tick_o(ms_tick),
        .ms_cnt_o (ms_cnt)
    );

    // Expiry of the current state's timer. DET also counts as expired once the counter
    // has run past DETACH_MS, so a late detach release still leaves on its first free cycle.
    always_comb begin
        t_exp = 1'b0;
        case (state_q)
            ST_WAIT: t_exp = ms_tick && (ms_cnt == CONN_M1);
            ST_SUSP: t_exp = (SUSPEND_DROP_MS != 0) && ms_tick && (ms_cnt == DROP_M1);
            ST_DET:  t_exp = (ms_tick && (ms_cnt == DET_M1)) || (ms_cnt >= DET_N);
            default: t_exp = 1'b0;
        endcase
    end

    assign state_nxt = next_state(state_q, bus.detach_i, sleep_s, t_exp);
    assign tmr_clr   = (state_nxt != state_q);
    assign tmr_hold  = (state_q == ST_WAIT) && bus.detach_i;

    // Counter value after this edge, so the WAIT blink lines up with ms_cnt itself.
    assign cnt_nxt = (tmr_clr || tmr_hold)            ? '0 :
                     (ms_tick && (ms_cnt != '1))      ? ms_cnt + 1'b1 : ms_cnt;

    // State register with outputs decoded from the next state so they change on the same edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_WAIT;
            pu_q    <= 1'b0;
            led_q   <= 1'b0;
            conn_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            case (state_nxt)
                ST_WAIT: begin pu_q <= 1'b0; led_q <= cnt_nxt[LED_BLINK_LOG2]; conn_q <= 1'b0; end
                ST_CONN: begin pu_q <= 1'b1; led_q <= 1'b1; conn_q <= 1'b1; end
                ST_SUSP: begin pu_q <= 1'b1; led_q <= 1'b0; conn_q <= 1'b1; end
                default: begin pu_q <= 1'b0; led_q <= 1'b0; conn_q <= 1'b0; end
            endcase
        end
    end

    assign bus.usb_pu_o    = pu_q;
    assign bus.led_o       = led_q;
    assign bus.state_o     = state_q;
    assign bus.connected_o = conn_q;
endmodule

// File: tb/tb_usb_conn_mgr.sv
// Directed bench for usb_conn_mgr; dut_a drops the pull-up after 3 ms of suspend, dut_b never does.
module tb_usb_conn_mgr;

    // {usb_pu_o, led_o, state_o[1:0], connected_o}
    localparam logic [4:0] O_WAIT0 = 5'b0_0_00_0;
    localparam logic [4:0] O_WAIT1 = 5'b0_1_00_0;
    localparam logic [4:0] O_CONN  = 5'b1_1_01_1;
    localparam logic [4:0] O_SUSP  = 5'b1_0_10_1;
    localparam logic [4:0] O_DET   = 5'b0_0_11_0;

    typedef struct {
        string      tag;
        logic [4:0] val;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    usb_conn_mgr_if if_a ();
    usb_conn_mgr_if if_b ();

    usb_conn_mgr #(
        .CLK_HZ(10_000), .CONNECT_MS(5), .DETACH_MS(2), .SUSPEND_DROP_MS(3),
        .LED_BLINK_LOG2(1), .SYNC_STAGES(2)
    ) dut_a (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (if_a.slave)
    );

    usb_conn_mgr #(
        .CLK_HZ(10_000), .CONNECT_MS(5), .DETACH_MS(2), .SUSPEND_DROP_MS(0),
        .LED_BLINK_LOG2(1), .SYNC_STAGES(2)
    ) dut_b (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs_a();
        return {if_a.usb_pu_o, if_a.led_o, if_a.state_o, if_a.connected_o};
    endfunction

    function automatic logic [4:0] obs_b();
        return {if_b.usb_pu_o, if_b.led_o, if_b.state_o, if_b.connected_o};
    endfunction

    task automatic push(input string tag, input logic [4:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [4:0] o);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", o);
            return;
        end
        e = sb.pop_front();
        assert (o === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", e.tag, o, e.val);
        end
    endtask

    task automatic exp_a(input string tag, input logic [4:0] v);
        push(tag, v);
        check(obs_a());
    endtask

    task automatic exp_b(input string tag, input logic [4:0] v);
        push(tag, v);
        check(obs_b());
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rstn         = 1'b0;
        if_a.sleep_i  = 1'b0;
        if_a.detach_i = 1'b0;
        if_b.sleep_i  = 1'b0;
        if_b.detach_i = 1'b0;
        adv(2);

        // Power-up sequence: 50 clk to connect, LED blinks with 2-ms half period.
        exp_a("reset_a", O_WAIT0);
        exp_b("reset_b", O_WAIT0);
        rstn = 1'b1;
        adv(19); exp_a("t1_led_off_19", O_WAIT0);
        adv(1);  exp_a("t1_led_on_20", O_WAIT1);
        adv(19); exp_a("t1_led_on_39", O_WAIT1);
        adv(1);  exp_a("t1_led_off_40", O_WAIT0);
        adv(9);  exp_a("t1_wait_49", O_WAIT0);
        adv(1);  exp_a("t1_conn_50", O_CONN);

        // Short suspend: 2-flop sync plus one FSM edge each way.
        if_a.sleep_i = 1'b1;
        adv(2);  exp_a("t2_conn_before_susp", O_CONN);
        adv(1);  exp_a("t2_susp", O_SUSP);
        adv(22); exp_a("t2_susp_held", O_SUSP);
        if_a.sleep_i = 1'b0;
        adv(2);  exp_a("t2_susp_before_resume", O_SUSP);
        adv(1);  exp_a("t2_resume", O_CONN);

        // Long suspend drops the pull-up after 3 ms, then the full reconnect.
        if_a.sleep_i = 1'b1;
        adv(3);  exp_a("t3_susp", O_SUSP);
        adv(29); exp_a("t3_susp_29", O_SUSP);
        adv(1);  exp_a("t3_drop_30", O_DET);
        if_a.sleep_i = 1'b0;
        adv(19); exp_a("t3_det_19", O_DET);
        adv(1);  exp_a("t3_wait_20", O_WAIT0);
        adv(49); exp_a("t3_wait_49", O_WAIT0);
        adv(1);  exp_a("t3_conn_50", O_CONN);

        // Detach pulse in SUSP, then a held detach keeps it in DET well past 2 ms.
        if_a.sleep_i = 1'b1;
        adv(3);  exp_a("t4_susp", O_SUSP);
        if_a.detach_i = 1'b1;
        adv(1);  exp_a("t4_det_pulse", O_DET);
        if_a.sleep_i  = 1'b0;
        adv(100); exp_a("t4_det_held", O_DET);
        if_a.detach_i = 1'b0;
        adv(1);  exp_a("t4_wait_release", O_WAIT0);
        adv(49); exp_a("t4_wait_49", O_WAIT0);
        adv(1);  exp_a("t4_conn_50", O_CONN);

        // Asynchronous reset mid-CONN clears outputs without a clock edge.
        #2;
        rstn = 1'b0;
        #1;
        exp_a("t5_async_reset", O_WAIT0);
        exp_b("t5_async_reset_b", O_WAIT0);
        adv(2);
        rstn = 1'b1;
        adv(20); exp_a("t5_led_on_20", O_WAIT1);
        adv(29); exp_a("t5_wait_49", O_WAIT0);
        adv(1);  exp_a("t5_conn_50", O_CONN);
        exp_b("t6_b_conn", O_CONN);

        // No-drop variant: suspend holds indefinitely with the pull-up on.
        if_b.sleep_i = 1'b1;
        adv(3);  exp_b("t6_susp", O_SUSP);
        for (int i = 0; i < 10; i++) begin
            adv(100);
            exp_b($sformatf("t6_susp_hold_%0d", i), O_SUSP);
        end
        if_b.sleep_i = 1'b0;
        adv(3);  exp_b("t6_resume", O_CONN);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
